// File: rtl/rv32i_imem_loader.sv
// rv32i_imem_loader: encodes symbolic RV32I requests into machine words and
// streams them into instruction memory at consecutive word addresses.
module rv32i_imem_loader #(
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [5:0]        in_op,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [31:0]       in_imm,
    input  logic              in_last,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] err_addr,
    output logic [ADDR_W:0]   count
);

    localparam logic [31:0]       NOP      = 32'h0000_0013;
    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
    localparam logic [6:0] OPC_LUI = 7'b0110111, OPC_AUIPC = 7'b0010111,
                           OPC_JAL = 7'b1101111, OPC_JALR  = 7'b1100111,
                           OPC_BR  = 7'b1100011, OPC_LOAD  = 7'b0000011,
                           OPC_ST  = 7'b0100011, OPC_OPI   = 7'b0010011,
                           OPC_OP  = 7'b0110011;
    localparam logic [6:0] F7_ALT = 7'b0100000;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
    typedef enum logic [2:0] {F_R, F_I, F_S, F_B, F_U, F_J, F_SH, F_BAD} fmt_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_addr;

    fmt_t        w_fmt;
    logic [6:0]  w_opc;
    logic [6:0]  w_f7;
    logic [2:0]  w_f3;
    logic [31:0] w_word;
    logic        w_legal;
    logic [31:0] w_enc;
    logic        w_i_ok, w_b_ok, w_j_ok, w_u_ok, w_sh_ok;
    logic        w_accept, w_ovf;

    // Immediate range checks for each instruction format
    assign w_i_ok  = (&in_imm[31:11]) | ~(|in_imm[31:11]);
    assign w_b_ok  = ((&in_imm[31:12]) | ~(|in_imm[31:12])) & ~in_imm[0];
    assign w_j_ok  = ((&in_imm[31:20]) | ~(|in_imm[31:20])) & ~in_imm[0];
    assign w_u_ok  = ~(|in_imm[11:0]);
    assign w_sh_ok = ~(|in_imm[31:5]);

    // Mnemonic decode: format, major opcode, funct3, funct7
    always_comb begin
        w_fmt = F_BAD;
        w_opc = OPC_OPI;
        w_f3  = 3'd0;
        w_f7  = 7'd0;
        case (in_op)
            6'd0:  begin w_fmt = F_U;  w_opc = OPC_LUI;   end
            6'd1:  begin w_fmt = F_U;  w_opc = OPC_AUIPC; end
            6'd2:  begin w_fmt = F_J;  w_opc = OPC_JAL;   end
            6'd3:  begin w_fmt = F_I;  w_opc = OPC_JALR;  end
            6'd4:  begin w_fmt = F_B;  w_opc = OPC_BR;   w_f3 = 3'd0; end
            6'd5:  begin w_fmt = F_B;  w_opc = OPC_BR;   w_f3 = 3'd1; end
            6'd6:  begin w_fmt = F_B;  w_opc = OPC_BR;   w_f3 = 3'd4; end
            6'd7:  begin w_fmt = F_B;  w_opc = OPC_BR;   w_f3 = 3'd5; end
            6'd8:  begin w_fmt = F_B;  w_opc = OPC_BR;   w_f3 = 3'd6; end
            6'd9:  begin w_fmt = F_B;  w_opc = OPC_BR;   w_f3 = 3'd7; end
            6'd10: begin w_fmt = F_I;  w_opc = OPC_LOAD; w_f3 = 3'd0; end
            6'd11: begin w_fmt = F_I;  w_opc = OPC_LOAD; w_f3 = 3'd1; end
            6'd12: begin w_fmt = F_I;  w_opc = OPC_LOAD; w_f3 = 3'd2; end
            6'd13: begin w_fmt = F_I;  w_opc = OPC_LOAD; w_f3 = 3'd4; end
            6'd14: begin w_fmt = F_I;  w_opc = OPC_LOAD; w_f3 = 3'd5; end
            6'd15: begin w_fmt = F_S;  w_opc = OPC_ST;   w_f3 = 3'd0; end
            6'd16: begin w_fmt = F_S;  w_opc = OPC_ST;   w_f3 = 3'd1; end
            6'd17: begin w_fmt = F_S;  w_opc = OPC_ST;   w_f3 = 3'd2; end
            6'd18: begin w_fmt = F_I;  w_f3 = 3'd0; end
            6'd19: begin w_fmt = F_I;  w_f3 = 3'd2; end
            6'd20: begin w_fmt = F_I;  w_f3 = 3'd3; end
            6'd21: begin w_fmt = F_I;  w_f3 = 3'd4; end
            6'd22: begin w_fmt = F_I;  w_f3 = 3'd6; end
            6'd23: begin w_fmt = F_I;  w_f3 = 3'd7; end
            6'd24: begin w_fmt = F_SH; w_f3 = 3'd1; end
            6'd25: begin w_fmt = F_SH; w_f3 = 3'd5; end
            6'd26: begin w_fmt = F_SH; w_f3 = 3'd5; w_f7 = F7_ALT; end
            6'd27: begin w_fmt = F_R;  w_opc = OPC_OP; w_f3 = 3'd0; end
            6'd28: begin w_fmt = F_R;  w_opc = OPC_OP; w_f3 = 3'd0; w_f7 = F7_ALT; end
            6'd29: begin w_fmt = F_R;  w_opc = OPC_OP; w_f3 = 3'd1; end
            6'd30: begin w_fmt = F_R;  w_opc = OPC_OP; w_f3 = 3'd2; end
            6'd31: begin w_fmt = F_R;  w_opc = OPC_OP; w_f3 = 3'd3; end
            6'd32: begin w_fmt = F_R;  w_opc = OPC_OP; w_f3 = 3'd4; end
            6'd33: begin w_fmt = F_R;  w_opc = OPC_OP; w_f3 = 3'd5; end
            6'd34: begin w_fmt = F_R;  w_opc = OPC_OP; w_f3 = 3'd5; w_f7 = F7_ALT; end
            6'd35: begin w_fmt = F_R;  w_opc = OPC_OP; w_f3 = 3'd6; end
            6'd36: begin w_fmt = F_R;  w_opc = OPC_OP; w_f3 = 3'd7; end
            default: w_fmt = F_BAD;
        endcase
    end

    // Field packing and legality per format
    always_comb begin
        w_word  = NOP;
        w_legal = 1'b0;
        case (w_fmt)
            F_R:  begin w_word = {w_f7, in_rs2, in_rs1, w_f3, in_rd, w_opc}; w_legal = 1'b1; end
            F_I:  begin w_word = {in_imm[11:0], in_rs1, w_f3, in_rd, w_opc}; w_legal = w_i_ok; end
            F_S:  begin
                w_word  = {in_imm[11:5], in_rs2, in_rs1, w_f3, in_imm[4:0], w_opc};
                w_legal = w_i_ok;
            end
            F_B:  begin
                w_word  = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, w_f3,
                           in_imm[4:1], in_imm[11], w_opc};
                w_legal = w_b_ok;
            end
            F_U:  begin w_word = {in_imm[31:12], in_rd, w_opc}; w_legal = w_u_ok; end
            F_J:  begin
                w_word  = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, w_opc};
                w_legal = w_j_ok;
            end
            F_SH: begin w_word = {w_f7, in_imm[4:0], in_rs1, w_f3, in_rd, w_opc}; w_legal = w_sh_ok; end
            default: begin w_word = NOP; w_legal = 1'b0; end
        endcase
    end

    assign w_enc    = w_legal ? w_word : NOP;
    assign in_ready = (r_state == S_RUN);
    assign busy     = (r_state == S_RUN);
    assign done     = (r_state == S_DONE);
    assign w_accept = in_valid && in_ready;
    assign w_ovf    = (r_addr == ADDR_MAX) && !in_last;

    // Session FSM, address/count tracking, error capture and write port
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_addr   <= '0;
            count    <= '0;
            err      <= 1'b0;
            err_addr <= '0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
        end else begin
            wr_en <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state  <= S_RUN;
                        r_addr   <= ADDR_W'(BASE_ADDR);
                        count    <= '0;
                        err      <= 1'b0;
                        err_addr <= '0;
                    end
                end
                S_RUN: begin
                    if (w_accept) begin
                        wr_en   <= 1'b1;
                        wr_addr <= r_addr;
                        wr_data <= w_enc;
                        count   <= count + (ADDR_W+1)'(1);
                        if (!w_legal || w_ovf) begin
                            err <= 1'b1;
                            if (!err) err_addr <= r_addr;
                        end
                        if (in_last || r_addr == ADDR_MAX) begin
                            r_state <= S_DONE;
                        end else begin
                            r_addr <= r_addr + ADDR_W'(1);
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rv32i_imem_loader.sv
// Self-checking bench for rv32i_imem_loader: directed vectors plus a random
// stream compared against an arithmetic reference encoder and session model.
module tb_rv32i_imem_loader;

    localparam int unsigned ADDR_W = 10;
    localparam int          MAXA   = (1 << ADDR_W) - 1;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic              clk = 1'b0;
    logic              reset, start, in_valid, in_last;
    logic              in_ready, wr_en, busy, done, err;
    logic [5:0]        in_op;
    logic [4:0]        in_rd, in_rs1, in_rs2;
    logic [31:0]       in_imm, wr_data;
    logic [ADDR_W-1:0] wr_addr, err_addr;
    logic [ADDR_W:0]   count;

    int checks = 0;
    int errors = 0;
    int m_addr, m_count, m_err_addr;
    bit m_err;

    // funct3 for each legal mnemonic code 0..36
    int f3tab [0:36] = '{0,0,0,0, 0,1,4,5,6,7, 0,1,2,4,5, 0,1,2,
                         0,2,3,4,6,7,1,5,5, 0,0,1,2,3,4,5,5,6,7};

    rv32i_imem_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(0)) dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
        .in_ready(in_ready), .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1),
        .in_rs2(in_rs2), .in_imm(in_imm), .in_last(in_last), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .done(done),
        .err(err), .err_addr(err_addr), .count(count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference encoder: ranges expressed as signed arithmetic bounds
    function automatic void ref_enc(input int op, input logic [4:0] rd, rs1, rs2,
                                    input logic [31:0] imm,
                                    output logic [31:0] w, output bit ok);
        logic signed [31:0] s;
        logic [2:0] f3;
        logic [6:0] f7, opc;
        s  = imm;
        ok = 1'b0;
        w  = NOP;
        if (op < 0 || op >= 37) return;
        f3 = 3'(f3tab[op]);
        f7 = (op == 26 || op == 28 || op == 34) ? 7'b0100000 : 7'b0000000;
        if (op <= 1) begin
            ok  = (imm % 4096) == 0;
            opc = (op == 0) ? 7'b0110111 : 7'b0010111;
            w   = {imm[31:12], rd, opc};
        end else if (op == 2) begin
            ok = (s >= -(1 << 20)) && (s < (1 << 20)) && (imm % 2 == 0);
            w  = {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
        end else if (op >= 4 && op <= 9) begin
            ok = (s >= -4096) && (s <= 4095) && (imm % 2 == 0);
            w  = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
        end else if (op >= 15 && op <= 17) begin
            ok = (s >= -2048) && (s <= 2047);
            w  = {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
        end else if (op >= 24 && op <= 26) begin
            ok = imm < 32;
            w  = {f7, imm[4:0], rs1, f3, rd, 7'b0010011};
        end else if (op >= 27) begin
            ok = 1'b1;
            w  = {f7, rs2, rs1, f3, rd, 7'b0110011};
        end else begin
            ok  = (s >= -2048) && (s <= 2047);
            opc = (op == 3) ? 7'b1100111 : (op <= 14) ? 7'b0000011 : 7'b0010011;
            w   = {imm[11:0], rs1, f3, rd, opc};
        end
        if (!ok) w = NOP;
    endfunction

    task automatic begin_session();
        start = 1'b1;
        tick();
        start = 1'b0;
        m_addr = 0; m_count = 0; m_err = 1'b0; m_err_addr = 0;
        chk("start_busy", busy, 1);
        chk("start_count", count, 0);
        chk("start_err", err, 0);
    endtask

    // Drive one request for one cycle and check the resulting write
    task automatic send(input int op, input logic [4:0] rd, rs1, rs2,
                        input logic [31:0] imm, input bit last);
        logic [31:0] exp_w;
        bit ok, ovf;
        chk("ready", in_ready, 1);
        in_valid = 1'b1; in_op = 6'(op); in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
        in_imm = imm; in_last = last;
        tick();
        in_valid = 1'b0;
        ref_enc(op, rd, rs1, rs2, imm, exp_w, ok);
        ovf = (m_addr == MAXA) && !last;
        if ((!ok || ovf) && !m_err) m_err_addr = m_addr;
        if (!ok || ovf) m_err = 1'b1;
        m_count++;
        chk("wr_en", wr_en, 1);
        chk("wr_addr", wr_addr, 64'(m_addr));
        chk($sformatf("wr_data op%0d", op), wr_data, exp_w);
        chk("count", count, 64'(m_count));
        chk("err", err, 64'(m_err));
        chk("err_addr", err_addr, 64'(m_err_addr));
        chk("done", done, 64'(last || m_addr == MAXA));
        chk("busy", busy, 64'(!(last || m_addr == MAXA)));
        m_addr++;
    endtask

    function automatic logic [31:0] rand_imm();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 5))
            0: rand_imm = r;
            1: rand_imm = {{20{r[11]}}, r[11:0]};
            2: rand_imm = {{19{r[12]}}, r[12:1], 1'b0};
            3: rand_imm = {r[31:12], 12'h000};
            4: rand_imm = 32'($urandom_range(0, 40));
            default: rand_imm = {{11{r[20]}}, r[20:1], 1'b0};
        endcase
    endfunction

    initial begin
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        in_op = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
        repeat (3) tick();
        chk("rst_ready", in_ready, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_err_addr", err_addr, 0);
        chk("rst_count", count, 0);
        reset = 1'b0;
        tick();

        // start together with in_valid in IDLE: no request accepted
        in_valid = 1'b1; in_op = 6'd18; in_rd = 5'd1; in_imm = 32'd5;
        begin_session();
        in_valid = 1'b0;
        tick();
        chk("start_no_accept_wr_en", wr_en, 0);
        chk("start_no_accept_count", count, 0);
        send(18, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1);
        chk("addi_const", wr_data, 32'h0050_0093);
        tick();
        chk("done_ready", in_ready, 0);

        // back-to-back R-type and shift, restarted from DONE
        begin_session();
        send(27, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0);
        chk("add_const", wr_data, 32'h0020_81B3);
        send(28, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0);
        chk("sub_const", wr_data, 32'h4020_81B3);
        send(26, 5'd2, 5'd2, 5'd0, 32'd3, 1'b1);
        chk("srai_const", wr_data, 32'h4031_5113);
        chk("b2b_count", count, 3);
        chk("b2b_ready", in_ready, 0);

        // U/B/S/J vectors, then illegal immediates
        begin_session();
        send(0, 5'd5, 5'd0, 5'd0, 32'h1234_5000, 1'b0);
        chk("lui_const", wr_data, 32'h1234_52B7);
        send(4, 5'd0, 5'd1, 5'd2, -32'sd8, 1'b0);
        chk("beq_const", wr_data, 32'hFE20_8CE3);
        send(17, 5'd0, 5'd1, 5'd2, 32'd8, 1'b0);
        chk("sw_const", wr_data, 32'h0020_A423);
        send(2, 5'd1, 5'd0, 5'd0, 32'd2048, 1'b0);
        chk("jal_const", wr_data, 32'h0010_00EF);
        send(18, 5'd1, 5'd0, 5'd0, 32'd2048, 1'b0);
        chk("addi2048_nop", wr_data, NOP);
        tick();
        chk("gap_wr_en", wr_en, 0);
        send(22, 5'd4, 5'd4, 5'd0, 32'd7, 1'b0);
        send(24, 5'd1, 5'd1, 5'd0, 32'd32, 1'b1);
        chk("slli32_nop", wr_data, NOP);
        chk("illegal_err", err, 1);
        chk("illegal_err_addr", err_addr, 4);

        // random stream to overflow at the top word address
        begin_session();
        while (m_count < MAXA + 1) begin
            if ($urandom_range(0, 3) == 0) begin
                tick();
                chk("rand_gap_wr_en", wr_en, 0);
            end else begin
                send($urandom_range(0, 63), 5'($urandom), 5'($urandom), 5'($urandom),
                     rand_imm(), 1'b0);
            end
        end
        chk("ovf_done", done, 1);
        chk("ovf_err", err, 1);
        chk("ovf_count", count, 64'(MAXA + 1));
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("ovf_extra_wr_en", wr_en, 0);
        chk("ovf_extra_count", count, 64'(MAXA + 1));

        // reset in the cycle after an accept drops the pending write
        begin_session();
        in_valid = 1'b1; in_op = 6'd27; in_last = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0; in_valid = 1'b0;
        chk("mid_rst_wr_en", wr_en, 0);
        chk("mid_rst_ready", in_ready, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_count", count, 0);
        chk("mid_rst_wr_addr", wr_addr, 0);
        chk("mid_rst_wr_data", wr_data, 0);
        begin_session();
        send(19, 5'd7, 5'd8, 5'd0, -32'sd1, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
